i2c_csr_bridge: RTL

I2C target (slave) that turns I2C transfers from the board controller into accesses on the internal 5-bit CSR bus that feeds the `gpio` instances and other register blocks. It drives `csr_a`, `csr_di` and `csr_we`, and reads back the ORed `csr_do` of all blocks. It sits directly upstream of every CSR-mapped block. Protocol: a register-pointer byte, then data bytes, with auto-increment in both directions.

---
 rtl/sl28_pkg.sv | 20 ++
 rtl/sync_edge.sv | 34 +++
 rtl/i2c_csr_bridge.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/sl28_pkg.sv
// Shared types and CSR bus dimensions for the I2C-to-CSR bridge and the
// register blocks hanging off the CSR bus.
package sl28_pkg;

    localparam int CSR_AW = 5;
    localparam int CSR_DW = 8;

    typedef enum logic [3:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        REG,
        REG_ACK,
        WDATA,
        WDATA_ACK,
        RDATA,
        RACK
    } i2c_state_t;

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchroniser per bit plus a history flop for edge detection.
// All flops reset to 1 to match an idle, pulled-up bus.
module sync_edge #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] async_in,
    output logic [WIDTH-1:0] out,
    output logic [WIDTH-1:0] out_edge
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;
    logic [WIDTH-1:0] prev_q;

    // NOTE: sequential state always uses non-blocking assignments so every flop
    // samples the pre-edge value of its neighbour; blocking here would collapse the chain.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= '1;
            sync_q <= '1;
            prev_q <= '1;
        end else begin
            meta_q <= async_in;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign out      = sync_q;
    assign out_edge = sync_q ^ prev_q;

endmodule

// File: rtl/i2c_csr_bridge.sv
// I2C target that maps register-pointer + data-byte transfers onto the CSR bus,
// with pointer auto-increment on both reads and writes.
module i2c_csr_bridge
    import sl28_pkg::*;
#(
    parameter logic [6:0] I2C_ADDR = 7'h4a
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              scl,
    input  logic              sda_in,
    output logic              sda_oe,
    output logic [CSR_AW-1:0] csr_a,
    output logic [CSR_DW-1:0] csr_di,
    output logic              csr_we,
    input  logic [CSR_DW-1:0] csr_do
);

    logic [1:0] pins_s;
    logic [1:0] pins_edge;

    sync_edge #(.WIDTH(2)) u_sync (
        .clk      (clk),
        .rst      (rst),
        .async_in ({scl, sda_in}),
        .out      (pins_s),
        .out_edge (pins_edge)
    );

    logic scl_s, sda_s, scl_rise, scl_fall, bus_start, bus_stop;
    assign scl_s     = pins_s[1];
    assign sda_s     = pins_s[0];
    assign scl_rise  = pins_edge[1] & scl_s;
    assign scl_fall  = pins_edge[1] & ~scl_s;
    assign bus_start = pins_edge[0] & ~sda_s & scl_s;
    assign bus_stop  = pins_edge[0] & sda_s & scl_s;

    i2c_state_t        state_q, state_d;
    logic [3:0]        bit_cnt_q, bit_cnt_d;
    logic [CSR_DW-1:0] shift_q, shift_d;
    logic [CSR_DW-1:0] csr_di_q, csr_di_d;
    logic [CSR_AW-1:0] ptr_q, ptr_d;
    logic              rw_q, rw_d;
    logic              sda_oe_q, sda_oe_d;
    logic              csr_we_q, csr_we_d;

    logic [CSR_DW-1:0] shift_in;
    assign shift_in = {shift_q[CSR_DW-2:0], sda_s};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            csr_di_q  <= '0;
            ptr_q     <= '0;
            rw_q      <= 1'b0;
            sda_oe_q  <= 1'b0;
            csr_we_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            csr_di_q  <= csr_di_d;
            ptr_q     <= ptr_d;
            rw_q      <= rw_d;
            sda_oe_q  <= sda_oe_d;
            csr_we_q  <= csr_we_d;
        end
    end

    // In the ACK states sda_oe_q doubles as the phase flag: the first SCL fall
    // starts the ACK, the second one ends it.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // through the case leaves it unassigned and infers a latch.
        state_d = state_q;
        if (bus_start) begin
            state_d = ADDR;
        end else if (bus_stop) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:      state_d = IDLE;
                ADDR:      if (scl_rise && bit_cnt_q == 4'd7)
                               state_d = (shift_in[7:1] == I2C_ADDR) ? ADDR_ACK : IDLE;
                ADDR_ACK:  if (scl_fall && sda_oe_q) state_d = rw_q ? RDATA : REG;
                REG:       if (scl_rise && bit_cnt_q == 4'd7) state_d = REG_ACK;
                REG_ACK:   if (scl_fall && sda_oe_q) state_d = WDATA;
                WDATA:     if (scl_rise && bit_cnt_q == 4'd7) state_d = WDATA_ACK;
                WDATA_ACK: if (scl_fall && sda_oe_q) state_d = WDATA;
                RDATA:     if (scl_fall && bit_cnt_q == 4'd8) state_d = RACK;
                RACK: begin
                    if (scl_rise && sda_s) state_d = IDLE;
                    else if (scl_fall && bit_cnt_q == 4'd1) state_d = RDATA;
                end
                default:   state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        csr_di_d  = csr_di_q;
        rw_d      = rw_q;
        sda_oe_d  = sda_oe_q;
        csr_we_d  = 1'b0;
        ptr_d     = csr_we_q ? ptr_q + CSR_AW'(1) : ptr_q;

        if (bus_start || bus_stop) begin
            bit_cnt_d = '0;
            sda_oe_d  = 1'b0;
        end else begin
            case (state_q)
                ADDR, REG, WDATA: begin
                    if (scl_rise) begin
                        shift_d   = shift_in;
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        if (bit_cnt_q == 4'd7) begin
                            bit_cnt_d = '0;
                            if (state_q == ADDR) rw_d = shift_in[0];
                            if (state_q == REG)  ptr_d = shift_in[CSR_AW-1:0];
                            if (state_q == WDATA) begin
                                csr_di_d = shift_in;
                                csr_we_d = 1'b1;
                            end
                        end
                    end
                end
                ADDR_ACK, REG_ACK, WDATA_ACK: begin
                    if (scl_fall) begin
                        if (!sda_oe_q) begin
                            sda_oe_d = 1'b1;
                        end else if (state_q == ADDR_ACK && rw_q) begin
                            shift_d  = csr_do;
                            sda_oe_d = ~csr_do[CSR_DW-1];
                            ptr_d    = ptr_q + CSR_AW'(1);
                        end else begin
                            sda_oe_d = 1'b0;
                        end
                    end
                end
                RDATA: begin
                    if (scl_rise) begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end else if (scl_fall) begin
                        if (bit_cnt_q == 4'd8) begin
                            bit_cnt_d = '0;
                            sda_oe_d  = 1'b0;
                        end else begin
                            shift_d  = {shift_q[CSR_DW-2:0], 1'b0};
                            sda_oe_d = ~shift_q[CSR_DW-2];
                        end
                    end
                end
                RACK: begin
                    if (scl_rise && !sda_s) begin
                        bit_cnt_d = 4'd1;
                    end else if (scl_fall && bit_cnt_q == 4'd1) begin
                        bit_cnt_d = '0;
                        shift_d   = csr_do;
                        sda_oe_d  = ~csr_do[CSR_DW-1];
                        ptr_d     = ptr_q + CSR_AW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign sda_oe = sda_oe_q;
    assign csr_a  = ptr_q;
    assign csr_di = csr_di_q;
    assign csr_we = csr_we_q;

endmodule
